// File: rtl/jesd204_rx_cgs_if.sv
`default_nettype none
// ============================================================================
// Module      : jesd204_rx_cgs_if
// Description : Lane data bus for the JESD204 RX code-group synchronisation
//               block. It carries the decoded characters with their
//               per-character flags into the block, and the delayed data and
//               valid flag back out.
//   master : drives char/charisk/notintable/disperr, sees out_* results
//   slave  : the CGS block; consumes the lane and drives out_data,
//            out_charisk and out_valid
// Revision    : 1.0 - initial release
// ============================================================================
interface jesd204_rx_cgs_if #(
  parameter int DATA_PATH_WIDTH = 4
);
  logic [8*DATA_PATH_WIDTH-1:0] char;
  logic [DATA_PATH_WIDTH-1:0]   charisk;
  logic [DATA_PATH_WIDTH-1:0]   notintable;
  logic [DATA_PATH_WIDTH-1:0]   disperr;
  logic [8*DATA_PATH_WIDTH-1:0] out_data;
  logic [DATA_PATH_WIDTH-1:0]   out_charisk;
  logic                         out_valid;

  modport master (
    output char, charisk, notintable, disperr,
    input  out_data, out_charisk, out_valid
  );

  modport slave (
    input  char, charisk, notintable, disperr,
    output out_data, out_charisk, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/jesd204_rx_cgs.sv
`default_nettype none
// ============================================================================
// Module      : jesd204_rx_cgs
// Description : JESD204 receive code-group synchronisation for one lane.
//               Waits for K_BEATS consecutive all-K28.5 beats (INIT), then
//               waits for the first non-K character (CHECK) and forwards
//               data (DATA). Repeated error beats push the lane back to
//               INIT, and a run of clean beats forgives earlier errors.
// Ports       :
//   clk          - single clock
//   resetn       - asynchronous active-low reset
//   en           - lane enable; low holds the lane in INIT
//   rx           - lane bus (char/charisk/notintable/disperr in,
//                  out_data/out_charisk/out_valid out)
//   err_cnt_clr  - synchronous clear of err_cnt
//   cgs_ready    - state is CHECK or DATA
//   cgs_state    - INIT=0, CHECK=1, DATA=2
//   err_cnt      - saturating count of error beats
// Build option: JESD204_RX_CGS_ERR_CNT_EN - when defined, err_cnt counts
//               error beats; when undefined err_cnt is tied to zero and
//               err_cnt_clr is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module jesd204_rx_cgs #(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int K_BEATS         = 1,
  parameter int ERR_THRESHOLD   = 3,
  parameter int GOOD_BEATS      = 4
) (
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             en,
  jesd204_rx_cgs_if.slave       rx,
  input  wire logic             err_cnt_clr,
  output logic                  cgs_ready,
  output logic [1:0]            cgs_state,
  output logic [31:0]           err_cnt
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] c_k_beats       = 4'(K_BEATS);
  localparam logic [3:0] c_err_threshold = 4'(ERR_THRESHOLD);
  localparam logic [3:0] c_good_beats    = 4'(GOOD_BEATS);
  localparam logic [7:0] c_k28_5         = 8'hBC;

  state_t                       r_state;
  logic [3:0]                   r_k_cnt;
  logic [3:0]                   r_err_run;
  logic [3:0]                   r_good_cnt;
  logic [8*DATA_PATH_WIDTH-1:0] r_out_data;
  logic [DATA_PATH_WIDTH-1:0]   r_out_charisk;
  logic                         r_out_valid;
  logic                         r_cgs_ready;

  logic [DATA_PATH_WIDTH-1:0]   w_char_is_bc;
  logic                         w_err_beat;
  logic                         w_k_beat;
  logic [3:0]                   w_k_cnt_inc;
  logic [3:0]                   w_err_run_inc;
  logic [3:0]                   w_good_cnt_inc;

  state_t                       w_state_nxt;
  logic [3:0]                   w_k_cnt_nxt;
  logic [3:0]                   w_err_run_nxt;
  logic [3:0]                   w_good_cnt_nxt;

  // --------------------------------------------------------------------------
  // Beat classification
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DATA_PATH_WIDTH; gi++) begin : g_char_cmp
      assign w_char_is_bc[gi] = (rx.char[8*gi +: 8] == c_k28_5);
    end
  endgenerate

  assign w_err_beat     = |{rx.notintable, rx.disperr};
  // A K beat must be clean: a BC with a disparity error does not count.
  assign w_k_beat       = (&w_char_is_bc) & (&rx.charisk) & ~w_err_beat;

  assign w_k_cnt_inc    = r_k_cnt + 4'd1;
  assign w_err_run_inc  = r_err_run + 4'd1;
  assign w_good_cnt_inc = r_good_cnt + 4'd1;

  // --------------------------------------------------------------------------
  // Next-state and counter update
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_k_cnt_nxt    = r_k_cnt;
    w_err_run_nxt  = r_err_run;
    w_good_cnt_nxt = r_good_cnt;

    if (!en) begin
      w_state_nxt    = ST_INIT;
      w_k_cnt_nxt    = 4'd0;
      w_err_run_nxt  = 4'd0;
      w_good_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (w_k_beat) begin
            if (w_k_cnt_inc == c_k_beats) begin
              w_state_nxt = ST_CHECK;
              w_k_cnt_nxt = 4'd0;
            end else begin
              w_k_cnt_nxt = w_k_cnt_inc;
            end
          end else begin
            w_k_cnt_nxt = 4'd0;
          end
        end

        ST_CHECK, ST_DATA: begin
          if (w_err_beat) begin
            w_good_cnt_nxt = 4'd0;
            // Threshold is at most 15, so the 4-bit run never wraps before
            // it is caught here.
            if (w_err_run_inc == c_err_threshold) begin
              w_state_nxt   = ST_INIT;
              w_err_run_nxt = 4'd0;
              w_k_cnt_nxt   = 4'd0;
            end else begin
              w_err_run_nxt = w_err_run_inc;
            end
          end else begin
            if (w_good_cnt_inc == c_good_beats) begin
              w_err_run_nxt  = 4'd0;
              w_good_cnt_nxt = 4'd0;
            end else begin
              w_good_cnt_nxt = w_good_cnt_inc;
            end
            // Only char 0 decides the end of CGS; DATA never goes back.
            if ((r_state == ST_CHECK) && !rx.charisk[0]) begin
              w_state_nxt = ST_DATA;
            end
          end
        end

        default: begin
          w_state_nxt    = ST_INIT;
          w_k_cnt_nxt    = 4'd0;
          w_err_run_nxt  = 4'd0;
          w_good_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_INIT;
      r_k_cnt       <= 4'd0;
      r_err_run     <= 4'd0;
      r_good_cnt    <= 4'd0;
      r_out_data    <= '0;
      r_out_charisk <= '0;
      r_out_valid   <= 1'b0;
      r_cgs_ready   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_k_cnt       <= w_k_cnt_nxt;
      r_err_run     <= w_err_run_nxt;
      r_good_cnt    <= w_good_cnt_nxt;
      r_out_data    <= rx.char;
      r_out_charisk <= rx.charisk;
      // Valid follows the state the beat leads into, so the beat that
      // enters DATA is valid and the one that leaves it is not.
      r_out_valid   <= (w_state_nxt == ST_DATA);
      r_cgs_ready   <= (w_state_nxt != ST_INIT);
    end
  end

  assign rx.out_data    = r_out_data;
  assign rx.out_charisk = r_out_charisk;
  assign rx.out_valid   = r_out_valid;
  assign cgs_ready      = r_cgs_ready;
  assign cgs_state      = r_state;

  // --------------------------------------------------------------------------
  // Error beat statistics
  // --------------------------------------------------------------------------
`ifdef JESD204_RX_CGS_ERR_CNT_EN
  logic [31:0] r_err_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_cnt <= 32'd0;
    end else if (err_cnt_clr) begin
      r_err_cnt <= 32'd0;
    end else if (w_err_beat && (r_err_cnt != 32'hFFFF_FFFF)) begin
      r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err_cnt_clr;

  assign w_unused_err_cnt_clr = err_cnt_clr;
  assign err_cnt              = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jesd204_rx_cgs.sv
`default_nettype none
// ============================================================================
// Module      : tb_jesd204_rx_cgs
// Description : Self-checking bench for jesd204_rx_cgs. Directed scenarios
//               followed by a randomised beat stream compared against a
//               behavioural lane model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd204_rx_cgs;

  localparam int DPW = 4;
  localparam int KB  = 1;
  localparam int ETH = 3;
  localparam int GB  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        err_cnt_clr = 1'b0;
  logic        cgs_ready;
  logic [1:0]  cgs_state;
  logic [31:0] err_cnt;

  int checks = 0;
  int errors = 0;

  jesd204_rx_cgs_if #(.DATA_PATH_WIDTH(DPW)) bus ();

  jesd204_rx_cgs #(
    .DATA_PATH_WIDTH (DPW),
    .K_BEATS         (KB),
    .ERR_THRESHOLD   (ETH),
    .GOOD_BEATS      (GB)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .en          (en),
    .rx          (bus),
    .err_cnt_clr (err_cnt_clr),
    .cgs_ready   (cgs_ready),
    .cgs_state   (cgs_state),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural lane model
  int          m_state;
  int          m_kc;
  int          m_ec;
  int          m_gc;
  logic [31:0] m_data;
  logic [3:0]  m_k;
  longint      m_errs;

  function automatic void model_reset();
    m_state = 0; m_kc = 0; m_ec = 0; m_gc = 0;
    m_data = '0; m_k = '0; m_errs = 0;
  endfunction

  function automatic void model_step(input logic [31:0] c, input logic [3:0] k,
                                     input logic [3:0] nit, input logic [3:0] de,
                                     input logic e, input logic clr);
    bit err;
    bit kb;
    int nxt;
    err = ((nit | de) != 4'd0);
    kb  = !err && (k == 4'hF);
    for (int i = 0; i < DPW; i++) if (c[8*i +: 8] != 8'hBC) kb = 0;
    m_data = c;
    m_k    = k;
    if (clr) m_errs = 0;
    else if (err && m_errs < 64'h0000_0000_FFFF_FFFF) m_errs++;
    nxt = m_state;
    if (!e) begin
      nxt = 0; m_kc = 0; m_ec = 0; m_gc = 0;
    end else if (m_state == 0) begin
      m_kc = kb ? m_kc + 1 : 0;
      if (m_kc >= KB) begin nxt = 1; m_kc = 0; end
    end else if (err) begin
      m_gc = 0;
      m_ec++;
      if (m_ec >= ETH) begin nxt = 0; m_ec = 0; m_kc = 0; end
    end else begin
      m_gc++;
      if (m_gc >= GB) begin m_ec = 0; m_gc = 0; end
      if (m_state == 1 && !k[0]) nxt = 2;
    end
    m_state = nxt;
  endfunction

  function automatic logic [31:0] exp_err_cnt();
`ifdef JESD204_RX_CGS_ERR_CNT_EN
    return m_errs[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_state"},   32'(cgs_state),       32'(m_state));
    chk({tag, "_ready"},   32'(cgs_ready),       32'(m_state != 0));
    chk({tag, "_valid"},   32'(bus.out_valid),   32'(m_state == 2));
    chk({tag, "_data"},    bus.out_data,         m_data);
    chk({tag, "_charisk"}, 32'(bus.out_charisk), 32'(m_k));
    chk({tag, "_errcnt"},  err_cnt,              exp_err_cnt());
  endtask

  task automatic drive(input string tag, input logic [31:0] c, input logic [3:0] k,
                       input logic [3:0] nit, input logic [3:0] de);
    @(negedge clk);
    bus.char = c; bus.charisk = k; bus.notintable = nit; bus.disperr = de;
    @(posedge clk);
    model_step(c, k, nit, de, en, err_cnt_clr);
    #1;
    check_all(tag);
  endtask

  task automatic k_beat(input string tag);
    drive(tag, 32'hBCBC_BCBC, 4'hF, 4'h0, 4'h0);
  endtask

  task automatic good_beat(input string tag);
    drive(tag, $urandom, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic err_beat(input string tag);
    drive(tag, $urandom, 4'h0, 4'h0, 4'b0001);
  endtask

  logic [31:0] base_errs;

  initial begin
    bus.char = '0; bus.charisk = '0; bus.notintable = '0; bus.disperr = '0;
    model_reset();
    en = 1'b1;
    #12;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // CGS entry from a single K beat
    k_beat("req034");
    chk("req034_state", 32'(cgs_state), 32'd1);
    chk("req034_ready", 32'(cgs_ready), 32'd1);

    // First data character moves to DATA and is itself valid
    drive("req035", 32'h0302_0100, 4'h0, 4'h0, 4'h0);
    chk("req035_state", 32'(cgs_state), 32'd2);
    chk("req035_valid", 32'(bus.out_valid), 32'd1);
    chk("req035_data", bus.out_data, 32'h0302_0100);

    // Three errors with short good gaps reach the threshold
    err_beat("req036_e1"); good_beat("req036_g"); good_beat("req036_g");
    err_beat("req036_e2"); good_beat("req036_g"); good_beat("req036_g");
    err_beat("req036_e3");
    chk("req036_state", 32'(cgs_state), 32'd0);
    chk("req036_valid", 32'(bus.out_valid), 32'd0);

    // A full good run forgives earlier errors
    k_beat("req037_k");
    good_beat("req037_enter");
    base_errs = m_errs[31:0];
    err_beat("req037_e"); err_beat("req037_e");
    for (int i = 0; i < 4; i++) good_beat("req037_g");
    err_beat("req037_e"); err_beat("req037_e");
    chk("req037_state", 32'(cgs_state), 32'd2);
`ifdef JESD204_RX_CGS_ERR_CNT_EN
    chk("req037_errcnt", err_cnt, base_errs + 32'd4);
`else
    chk("req037_errcnt", err_cnt, 32'd0);
`endif

    // Enable drop forces INIT on the next edge
    en = 1'b0;
    good_beat("req038_en");
    chk("req038_en_state", 32'(cgs_state), 32'd0);
    en = 1'b1;
    k_beat("req038_k");
    good_beat("req038_data");
    err_beat("req038_e");

    // Asynchronous reset mid-DATA
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all("req038_rst");
    chk("req038_rst_state", 32'(cgs_state), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    k_beat("req038_k2");
    good_beat("req038_data2");
    // Two errors must not trip the threshold: the run was zeroed by reset
    err_beat("req038_e1"); err_beat("req038_e2");
    chk("req038_run_state", 32'(cgs_state), 32'd2);

    // Clear wins over a simultaneous error beat
    err_cnt_clr = 1'b1;
    err_beat("req038_clr");
    chk("req038_clr_errcnt", err_cnt, 32'd0);
    err_cnt_clr = 1'b0;

    // Randomised beat stream
    for (int n = 0; n < 600; n++) begin
      int          r;
      logic [31:0] c;
      logic [3:0]  k;
      logic [3:0]  nit;
      logic [3:0]  de;
      en          = ($urandom_range(0, 99) >= 3);
      err_cnt_clr = ($urandom_range(0, 99) < 3);
      r   = $urandom_range(0, 99);
      c   = $urandom;
      k   = 4'h0;
      nit = 4'h0;
      de  = 4'h0;
      if (r < 30) begin
        c = 32'hBCBC_BCBC; k = 4'hF;
      end else if (r < 75) begin
        if ($urandom_range(0, 9) == 0) k = 4'($urandom);
      end else if (r < 88) begin
        if ($urandom_range(0, 1) == 0) nit = 4'(1 << $urandom_range(0, 3));
        else de = 4'(1 << $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) begin c = 32'hBCBC_BCBC; k = 4'hF; end
      end else begin
        c = 32'hBCBC_BCBC; k = 4'hF;
        if ($urandom_range(0, 1) == 0) c[8*$urandom_range(0, 3) +: 8] = 8'h1C;
        else k[$urandom_range(0, 3)] = 1'b0;
      end
      drive("rand", c, k, nit, de);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jesd204_rx_cgs.md
JESD204_RX_CGS -- requirements
Module: jesd204_rx_cgs

Interface
- REQ-001: Parameter DATA_PATH_WIDTH, default 4; characters per lane per clock (beat).
- REQ-002: Parameter K_BEATS, default 1; consecutive all-K28.5 beats needed to leave INIT, range 1..15.
- REQ-003: Parameter ERR_THRESHOLD, default 3; error beats in CHECK/DATA that force INIT, range 1..15.
- REQ-004: Parameter GOOD_BEATS, default 4; consecutive error-free beats that clear the error count, range 1..15.
- REQ-005: clk  input  1  single clock; all logic is in this domain.
- REQ-006: resetn  input  1  asynchronous, active-low reset.
- REQ-007: en  input  1  lane enable; low forces INIT.
- REQ-008: char  input  8*DATA_PATH_WIDTH  decoded characters, char 0 in bits [7:0].
- REQ-009: charisk  input  DATA_PATH_WIDTH  per-character K flag.
- REQ-010: notintable  input  DATA_PATH_WIDTH  per-character not-in-table flag.
- REQ-011: disperr  input  DATA_PATH_WIDTH  per-character disparity error flag.
- REQ-012: out_data  output  8*DATA_PATH_WIDTH  char delayed one cycle.
- REQ-013: out_charisk  output  DATA_PATH_WIDTH  charisk delayed one cycle.
- REQ-014: out_valid  output  1  out_data belongs to DATA state.
- REQ-015: cgs_ready  output  1  state is CHECK or DATA.
- REQ-016: cgs_state  output  2  INIT=0, CHECK=1, DATA=2.
- REQ-017: err_cnt_clr  input  1  synchronous clear of err_cnt.
- REQ-018: err_cnt  output  32  saturating count of error beats.

Function
- REQ-019: A beat is an error beat when any bit of notintable or disperr is set.
- REQ-020: A beat is a K beat when every character is 8'hBC with charisk set and the beat is not an error beat.
- REQ-021: INIT: count consecutive K beats; any other beat zeroes the count; on reaching K_BEATS, go to CHECK next cycle.
- REQ-022: CHECK: a non-error beat whose char 0 is not K (charisk[0]=0) goes to DATA; K beats stay in CHECK.
- REQ-023: CHECK/DATA: each error beat increments a 4-bit error count; a beat that makes the count equal ERR_THRESHOLD goes to INIT and zeroes all counters.
- REQ-024: CHECK/DATA: GOOD_BEATS consecutive non-error beats zero the error count; the good-run counter resets on any error beat.
- REQ-025: DATA never returns to CHECK; the only exit is to INIT.
- REQ-026: en low: next state INIT and counters zeroed, with priority over all transitions.
- REQ-027: Latency: inputs sampled at edge N appear on out_data/out_charisk at edge N+1; cgs_state updates at edge N+1.
- REQ-028: out_valid is registered as (next state == DATA), so the beat that triggers CHECK->DATA is valid and the beat that triggers DATA->INIT is not.
- REQ-029: err_cnt increments by 1 per error beat in any state, saturates at 32'hFFFFFFFF, and takes err_cnt_clr with priority over increment.

Reset
- REQ-030: resetn low asynchronously forces cgs_state=INIT, out_valid=0, cgs_ready=0, out_data=0, out_charisk=0, err_cnt=0 and all internal counters to 0.
- REQ-031: Reset release is synchronous to clk; the first sampled beat is evaluated in INIT.

Configuration
- REQ-032: Macro JESD204_RX_CGS_ERR_CNT_EN defined: err_cnt behaves per REQ-029.
- REQ-033: Macro JESD204_RX_CGS_ERR_CNT_EN undefined: err_cnt is constant 0, err_cnt_clr is ignored, no counter logic is built, and all other behaviour is unchanged.

Verification
- REQ-034: Defaults; reset, then 1 beat of 4x BC/K -> cgs_state=1 and cgs_ready=1 one cycle later.
- REQ-035: In CHECK, send beat 0x03020100 with charisk=0 -> cgs_state=2, and out_valid=1 with out_data=0x03020100 on the same edge.
- REQ-036: In DATA, send 3 beats with disperr=4'b0001, separated by 2 good beats each -> INIT after the third; out_valid=0 for that beat.
- REQ-037: In DATA, send 2 error beats, 4 good beats, then 2 error beats -> stays in DATA; err_cnt=4 with macro, 0 without.
- REQ-038: Drop en or pulse resetn mid-DATA -> INIT next edge (resetn: immediately); counters zeroed; err_cnt_clr together with an error beat -> err_cnt=0.
